// File: rtl/fu_issue_arbiter_pkg.sv
// Shared types and constants for the functional-unit issue arbiter.
// Holds the store-drain FSM state encoding and the ROB index width.
package fu_issue_arbiter_pkg;

   localparam int ROB_IDX_SIZE = 5;

   localparam int FU_ARB_STORE_DRAIN_CYCLES = 2;

   typedef logic [ROB_IDX_SIZE-1:0] rob_idx_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_DRAIN1 = 2'd1,
      ARB_DRAIN2 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Request/grant/issue-record bundle between the reservation stations, ROB and the arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants and the record.
interface fu_issue_arbiter_if;
   import fu_issue_arbiter_pkg::*;

   logic     in_alu_req;
   rob_idx_t in_alu_rob_index;
   logic     in_ls_req;
   logic     in_ls_is_store;
   rob_idx_t in_ls_rob_index;
   rob_idx_t in_rob_head_index;
   logic     in_flush;

   logic     out_alu_grant;
   logic     out_ls_grant;
   logic     out_busy;
   logic     out_issue_valid;
   rob_idx_t out_issue_rob_index;
   logic     out_issue_is_ls;

   modport master (
      output in_alu_req, in_alu_rob_index, in_ls_req, in_ls_is_store,
             in_ls_rob_index, in_rob_head_index, in_flush,
      input  out_alu_grant, out_ls_grant, out_busy, out_issue_valid,
             out_issue_rob_index, out_issue_is_ls
   );

   modport slave (
      input  in_alu_req, in_alu_rob_index, in_ls_req, in_ls_is_store,
             in_ls_rob_index, in_rob_head_index, in_flush,
      output out_alu_grant, out_ls_grant, out_busy, out_issue_valid,
             out_issue_rob_index, out_issue_is_ls
   );

endinterface

// File: rtl/fu_issue_arbiter_ls_store_drain_fsm.sv
// Store drain tracker: after a store issues, the dmem write port stays busy for
// FU_ARB_STORE_DRAIN_CYCLES cycles; flush does not abort it, reset does.
module ls_store_drain_fsm
   import fu_issue_arbiter_pkg::*;
(
   input  logic in_clk,
   input  logic in_rst,
   input  logic in_store_grant,
   output logic out_busy
);

   arb_state_t state_q, state_d;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE:   if (in_store_grant) state_d = ARB_DRAIN1;
         ARB_DRAIN1: state_d = ARB_DRAIN2;
         ARB_DRAIN2: state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge in_clk) begin
      if (in_rst) state_q <= ARB_IDLE;
      else        state_q <= state_d;
   end

   assign out_busy = (state_q != ARB_IDLE);

endmodule

// File: rtl/fu_issue_arbiter.sv
// Single-port issue arbiter for func_units: fixed ALU priority, stores held to the ROB head,
// LS blocked during store drain. Optional LS starvation guard: FU_ARB_STARVE_GUARD_EN.
module fu_issue_arbiter
   import fu_issue_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input logic               in_clk,
   input logic               in_rst,
   fu_issue_arbiter_if.slave arb
);

   logic     alu_ok;
   logic     ls_ok;
   logic     alu_grant;
   logic     ls_grant;
   logic     drain_busy;
   logic     store_at_head;

   logic     issue_valid_q, issue_valid_d;
   rob_idx_t issue_rob_index_q, issue_rob_index_d;
   logic     issue_is_ls_q, issue_is_ls_d;

   always_comb begin
      store_at_head = (arb.in_ls_rob_index == arb.in_rob_head_index);
      alu_ok = arb.in_alu_req & ~arb.in_flush & ~in_rst;
      ls_ok  = arb.in_ls_req & ~arb.in_flush & ~in_rst & ~drain_busy &
               (~arb.in_ls_is_store | store_at_head);
   end

`ifdef FU_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starved;

   assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

   // Once LS has lost STARVE_LIMIT times in a row it takes priority for one grant.
   always_comb begin
      alu_grant    = alu_ok & ~(starved & ls_ok);
      ls_grant     = ls_ok & (starved | ~alu_ok);
      starve_cnt_d = starve_cnt_q;
      if (ls_grant | arb.in_flush)
         starve_cnt_d = '0;
      else if (ls_ok & alu_ok & ~starved)
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;

   always_comb begin
      alu_grant = alu_ok;
      ls_grant  = ls_ok & ~alu_ok;
   end
`endif

   ls_store_drain_fsm u_drain (
      .in_clk         (in_clk),
      .in_rst         (in_rst),
      .in_store_grant (ls_grant & arb.in_ls_is_store),
      .out_busy       (drain_busy)
   );

   // The index holds across idle cycles so the ROB side can still read the last issue.
   always_comb begin
      issue_valid_d     = alu_grant | ls_grant;
      issue_is_ls_d     = ls_grant;
      issue_rob_index_d = issue_rob_index_q;
      if (alu_grant)     issue_rob_index_d = arb.in_alu_rob_index;
      else if (ls_grant) issue_rob_index_d = arb.in_ls_rob_index;
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         issue_valid_q     <= 1'b0;
         issue_rob_index_q <= '0;
         issue_is_ls_q     <= 1'b0;
      end else begin
         issue_valid_q     <= issue_valid_d;
         issue_rob_index_q <= issue_rob_index_d;
         issue_is_ls_q     <= issue_is_ls_d;
      end
   end

   assign arb.out_alu_grant       = alu_grant;
   assign arb.out_ls_grant        = ls_grant;
   assign arb.out_busy            = drain_busy;
   assign arb.out_issue_valid     = issue_valid_q;
   assign arb.out_issue_rob_index = issue_rob_index_q;
   assign arb.out_issue_is_ls     = issue_is_ls_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed self-checking bench for fu_issue_arbiter; inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_fu_issue_arbiter;
   import fu_issue_arbiter_pkg::*;

   logic in_clk;
   logic in_rst;
   int   errors = 0;
   int   checks = 0;

   fu_issue_arbiter_if arb_if ();

   fu_issue_arbiter #(.STARVE_LIMIT(4)) dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .arb    (arb_if.slave)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic cyc();
      @(negedge in_clk);
   endtask

   task automatic drive_idle();
      arb_if.in_alu_req        = 1'b0;
      arb_if.in_alu_rob_index  = '0;
      arb_if.in_ls_req         = 1'b0;
      arb_if.in_ls_is_store    = 1'b0;
      arb_if.in_ls_rob_index   = '0;
      arb_if.in_rob_head_index = '0;
      arb_if.in_flush          = 1'b0;
   endtask

   task automatic test_reset();
      in_rst = 1'b1;
      drive_idle();
      arb_if.in_alu_req = 1'b1;
      arb_if.in_ls_req  = 1'b1;
      cyc();
      #1;
      checks++;
      if (arb_if.out_alu_grant !== 1'b0) begin
         errors++; $display("FAIL reset_alu_grant: got %b expected 0", arb_if.out_alu_grant);
      end
      checks++;
      if (arb_if.out_ls_grant !== 1'b0) begin
         errors++; $display("FAIL reset_ls_grant: got %b expected 0", arb_if.out_ls_grant);
      end
      checks++;
      if (arb_if.out_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", arb_if.out_busy);
      end
      checks++;
      if (arb_if.out_issue_valid !== 1'b0) begin
         errors++; $display("FAIL reset_issue_valid: got %b expected 0", arb_if.out_issue_valid);
      end
      checks++;
      if (arb_if.out_issue_rob_index !== 5'd0) begin
         errors++; $display("FAIL reset_issue_index: got %0d expected 0", arb_if.out_issue_rob_index);
      end
      checks++;
      if (arb_if.out_issue_is_ls !== 1'b0) begin
         errors++; $display("FAIL reset_issue_is_ls: got %b expected 0", arb_if.out_issue_is_ls);
      end
      cyc();
      in_rst = 1'b0;
      drive_idle();
      cyc();
   endtask

   task automatic test_alu_priority();
      logic exp_alu;
      logic exp_ls;
      arb_if.in_alu_req       = 1'b1;
      arb_if.in_alu_rob_index = 5'd1;
      arb_if.in_ls_req        = 1'b1;
      arb_if.in_ls_is_store   = 1'b0;
      arb_if.in_ls_rob_index  = 5'd2;
      for (int i = 0; i < 10; i++) begin
`ifdef FU_ARB_STARVE_GUARD_EN
         exp_ls = (i == 4) || (i == 9);
`else
         exp_ls = 1'b0;
`endif
         exp_alu = ~exp_ls;
         #1;
         checks++;
         if (arb_if.out_alu_grant !== exp_alu) begin
            errors++; $display("FAIL prio_alu_grant cycle %0d: got %b expected %b", i + 1, arb_if.out_alu_grant, exp_alu);
         end
         checks++;
         if (arb_if.out_ls_grant !== exp_ls) begin
            errors++; $display("FAIL prio_ls_grant cycle %0d: got %b expected %b", i + 1, arb_if.out_ls_grant, exp_ls);
         end
         cyc();
      end
      drive_idle();
      cyc();
   endtask

   task automatic test_store_drain();
      arb_if.in_ls_req         = 1'b1;
      arb_if.in_ls_is_store    = 1'b1;
      arb_if.in_ls_rob_index   = 5'd5;
      arb_if.in_rob_head_index = 5'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (arb_if.out_ls_grant !== 1'b0) begin
            errors++; $display("FAIL store_not_head_grant: got %b expected 0", arb_if.out_ls_grant);
         end
         cyc();
      end
      arb_if.in_rob_head_index = 5'd5;
      #1;
      checks++;
      if (arb_if.out_ls_grant !== 1'b1) begin
         errors++; $display("FAIL store_at_head_grant: got %b expected 1", arb_if.out_ls_grant);
      end
      cyc();
      arb_if.in_ls_is_store  = 1'b0;
      arb_if.in_ls_rob_index = 5'd6;
      #1;
      checks++;
      if (arb_if.out_issue_valid !== 1'b1 || arb_if.out_issue_rob_index !== 5'd5 || arb_if.out_issue_is_ls !== 1'b1) begin
         errors++; $display("FAIL store_issue_record: got v=%b idx=%0d ls=%b expected v=1 idx=5 ls=1",
                            arb_if.out_issue_valid, arb_if.out_issue_rob_index, arb_if.out_issue_is_ls);
      end
      for (int k = 0; k < FU_ARB_STORE_DRAIN_CYCLES; k++) begin
         if (k != 0) #1;
         checks++;
         if (arb_if.out_busy !== 1'b1) begin
            errors++; $display("FAIL drain_busy cycle %0d: got %b expected 1", k + 1, arb_if.out_busy);
         end
         checks++;
         if (arb_if.out_ls_grant !== 1'b0) begin
            errors++; $display("FAIL drain_load_blocked cycle %0d: got %b expected 0", k + 1, arb_if.out_ls_grant);
         end
         cyc();
      end
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b0) begin
         errors++; $display("FAIL drain_done_busy: got %b expected 0", arb_if.out_busy);
      end
      checks++;
      if (arb_if.out_ls_grant !== 1'b1) begin
         errors++; $display("FAIL drain_done_load_grant: got %b expected 1", arb_if.out_ls_grant);
      end
      cyc();
      drive_idle();
      #1;
      checks++;
      if (arb_if.out_issue_rob_index !== 5'd6 || arb_if.out_issue_is_ls !== 1'b1) begin
         errors++; $display("FAIL load_issue_record: got idx=%0d ls=%b expected idx=6 ls=1",
                            arb_if.out_issue_rob_index, arb_if.out_issue_is_ls);
      end
      cyc();
   endtask

   task automatic test_flush();
      arb_if.in_alu_req        = 1'b1;
      arb_if.in_alu_rob_index  = 5'd8;
      arb_if.in_ls_req         = 1'b1;
      arb_if.in_ls_is_store    = 1'b1;
      arb_if.in_ls_rob_index   = 5'd9;
      arb_if.in_rob_head_index = 5'd9;
      arb_if.in_flush          = 1'b1;
      #1;
      checks++;
      if (arb_if.out_alu_grant !== 1'b0 || arb_if.out_ls_grant !== 1'b0) begin
         errors++; $display("FAIL flush_grants: got alu=%b ls=%b expected 0 0",
                            arb_if.out_alu_grant, arb_if.out_ls_grant);
      end
      cyc();
      drive_idle();
      #1;
      checks++;
      if (arb_if.out_issue_valid !== 1'b0) begin
         errors++; $display("FAIL flush_issue_valid: got %b expected 0", arb_if.out_issue_valid);
      end
      checks++;
      if (arb_if.out_busy !== 1'b0) begin
         errors++; $display("FAIL flush_no_drain: got %b expected 0", arb_if.out_busy);
      end
      cyc();
   endtask

   task automatic test_flush_during_drain();
      arb_if.in_ls_req         = 1'b1;
      arb_if.in_ls_is_store    = 1'b1;
      arb_if.in_ls_rob_index   = 5'd10;
      arb_if.in_rob_head_index = 5'd10;
      cyc();
      drive_idle();
      arb_if.in_flush = 1'b1;
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b1) begin
         errors++; $display("FAIL flush_drain_busy1: got %b expected 1", arb_if.out_busy);
      end
      cyc();
      arb_if.in_flush = 1'b0;
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b1) begin
         errors++; $display("FAIL flush_drain_busy2: got %b expected 1", arb_if.out_busy);
      end
      cyc();
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b0) begin
         errors++; $display("FAIL flush_drain_end: got %b expected 0", arb_if.out_busy);
      end
      cyc();
   endtask

   task automatic test_reset_mid_drain();
      arb_if.in_ls_req         = 1'b1;
      arb_if.in_ls_is_store    = 1'b1;
      arb_if.in_ls_rob_index   = 5'd12;
      arb_if.in_rob_head_index = 5'd12;
      cyc();
      in_rst                 = 1'b1;
      arb_if.in_ls_is_store  = 1'b0;
      arb_if.in_ls_rob_index = 5'd13;
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b1) begin
         errors++; $display("FAIL rst_drain_was_busy: got %b expected 1", arb_if.out_busy);
      end
      checks++;
      if (arb_if.out_ls_grant !== 1'b0) begin
         errors++; $display("FAIL rst_grant_forced_off: got %b expected 0", arb_if.out_ls_grant);
      end
      cyc();
      in_rst = 1'b0;
      #1;
      checks++;
      if (arb_if.out_busy !== 1'b0) begin
         errors++; $display("FAIL rst_drain_busy_cleared: got %b expected 0", arb_if.out_busy);
      end
      checks++;
      if (arb_if.out_ls_grant !== 1'b1) begin
         errors++; $display("FAIL rst_drain_load_grant: got %b expected 1", arb_if.out_ls_grant);
      end
      checks++;
      if (arb_if.out_issue_valid !== 1'b0) begin
         errors++; $display("FAIL rst_drain_issue_valid: got %b expected 0", arb_if.out_issue_valid);
      end
      cyc();
      drive_idle();
      cyc();
   endtask

   task automatic test_issue_record();
      arb_if.in_alu_req       = 1'b1;
      arb_if.in_alu_rob_index = 5'd7;
      #1;
      checks++;
      if (arb_if.out_alu_grant !== 1'b1) begin
         errors++; $display("FAIL rec_alu_grant: got %b expected 1", arb_if.out_alu_grant);
      end
      cyc();
      drive_idle();
      #1;
      checks++;
      if (arb_if.out_issue_valid !== 1'b1 || arb_if.out_issue_rob_index !== 5'd7 || arb_if.out_issue_is_ls !== 1'b0) begin
         errors++; $display("FAIL rec_alu_record: got v=%b idx=%0d ls=%b expected v=1 idx=7 ls=0",
                            arb_if.out_issue_valid, arb_if.out_issue_rob_index, arb_if.out_issue_is_ls);
      end
      cyc();
      #1;
      checks++;
      if (arb_if.out_issue_valid !== 1'b0 || arb_if.out_issue_rob_index !== 5'd7) begin
         errors++; $display("FAIL rec_idle_hold: got v=%b idx=%0d expected v=0 idx=7",
                            arb_if.out_issue_valid, arb_if.out_issue_rob_index);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      arb_if.in_alu_req        = 1'b1;
      arb_if.in_alu_rob_index  = 5'd4;
      arb_if.in_ls_req         = 1'b1;
      arb_if.in_ls_is_store    = 1'b1;
      arb_if.in_ls_rob_index   = 5'd31;
      arb_if.in_rob_head_index = 5'd31;
      #1;
      checks++;
      if (arb_if.out_alu_grant !== 1'b1 || arb_if.out_ls_grant !== 1'b0) begin
         errors++; $display("FAIL b2b_alu_first: got alu=%b ls=%b expected 1 0",
                            arb_if.out_alu_grant, arb_if.out_ls_grant);
      end
      cyc();
      arb_if.in_alu_req = 1'b0;
      #1;
      checks++;
      if (arb_if.out_ls_grant !== 1'b1) begin
         errors++; $display("FAIL b2b_store_retry: got %b expected 1", arb_if.out_ls_grant);
      end
      checks++;
      if (arb_if.out_issue_rob_index !== 5'd4 || arb_if.out_issue_is_ls !== 1'b0) begin
         errors++; $display("FAIL b2b_alu_record: got idx=%0d ls=%b expected idx=4 ls=0",
                            arb_if.out_issue_rob_index, arb_if.out_issue_is_ls);
      end
      cyc();
      drive_idle();
      #1;
      checks++;
      if (arb_if.out_issue_valid !== 1'b1 || arb_if.out_issue_rob_index !== 5'd31 || arb_if.out_issue_is_ls !== 1'b1) begin
         errors++; $display("FAIL b2b_store_record: got v=%b idx=%0d ls=%b expected v=1 idx=31 ls=1",
                            arb_if.out_issue_valid, arb_if.out_issue_rob_index, arb_if.out_issue_is_ls);
      end
      checks++;
      if (arb_if.out_busy !== 1'b1) begin
         errors++; $display("FAIL b2b_store_busy: got %b expected 1", arb_if.out_busy);
      end
      cyc();
      cyc();
      cyc();
   endtask

   initial begin
      in_rst = 1'b1;
      drive_idle();
      test_reset();
      test_alu_priority();
      test_store_drain();
      test_flush();
      test_flush_during_drain();
      test_reset_mid_drain();
      test_issue_record();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fu_issue_arbiter.md
# fu_issue_arbiter

Arbitrates between the ALU reservation station and the load/store reservation station for the single shared execute path in `func_units`, which has one operand/op register set and one ROB result port. Each cycle it grants at most one requester. It holds stores until their ROB entry is at the commit head. It blocks further load/store issue while a store drains into `dmem`. It also records each issue for ROB-side tracking. The grants drive `in_rs_alu_start` and `in_rs_ls_start` directly.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive lost LS arbitrations before LS is forced (guard build only); counter width is `$clog2(STARVE_LIMIT+1)`.

Ports:
- `in_clk`  in  1  clock; all state updates on posedge.
- `in_rst`  in  1  reset, synchronous, active-high.
- `in_alu_req`  in  1  ALU RS holds an issuable entry.
- `in_alu_rob_index`  in  `ROB_IDX_SIZE`  destination ROB index of that ALU entry.
- `in_ls_req`  in  1  LS RS holds an issuable entry.
- `in_ls_is_store`  in  1  LS entry is STUR.
- `in_ls_rob_index`  in  `ROB_IDX_SIZE`  destination ROB index of that LS entry.
- `in_rob_head_index`  in  `ROB_IDX_SIZE`  current ROB commit head.
- `in_flush`  in  1  mispredict squash this cycle.
- `out_alu_grant`  out  1  combinational; ALU entry issues this cycle.
- `out_ls_grant`  out  1  combinational; LS entry issues this cycle.
- `out_busy`  out  1  store drain in progress (registered state).
- `out_issue_valid`  out  1  registered; an op was granted last cycle.
- `out_issue_rob_index`  out  `ROB_IDX_SIZE`  registered; ROB index of last cycle's grant.
- `out_issue_is_ls`  out  1  registered; last cycle's grant was LS.

## Operation
- Eligibility:
  - `alu_ok = in_alu_req & !in_flush & !in_rst`.
  - `ls_ok = in_ls_req & !in_flush & !in_rst & state==ARB_IDLE & (!in_ls_is_store | in_ls_rob_index==in_rob_head_index)`.
- Base policy is fixed ALU priority:
  - `out_alu_grant = alu_ok`.
  - `out_ls_grant = ls_ok & !alu_ok`.
  - Grants are mutually exclusive.
- Store drain FSM, states `ARB_IDLE`, `ARB_DRAIN1`, `ARB_DRAIN2`:
  - `ARB_IDLE` goes to `ARB_DRAIN1` on a granted store.
  - `ARB_DRAIN1` goes to `ARB_DRAIN2` unconditionally.
  - `ARB_DRAIN2` goes to `ARB_IDLE` unconditionally.
  - While not idle, no LS grant (loads or stores); ALU is unaffected.
- `in_flush` does not abort a drain: the store was at the commit head, so it is architecturally committed.
- Issue record, updated each edge:
  - `out_issue_valid <= out_alu_grant | out_ls_grant`.
  - `out_issue_rob_index` takes the granted index; it holds its previous value when nothing is granted.
  - `out_issue_is_ls <= out_ls_grant`.
- Boundary cases:
  - Store at the head while ALU also requests: ALU wins; the store retries next cycle.
  - ROB index comparison is plain equality; wrap-around needs no special handling.
  - Flush and a store at the head in the same cycle: no grant.

## Timing
- Grant is combinational in the request cycle. `func_units` samples start at the following posedge.
- The issue record appears one cycle after the grant, aligned with `func_units` `out_rob_done`.
- `out_busy` is high for exactly the 2 cycles after the store grant edge. The next LS grant is possible in the 3rd cycle after the store grant.
- Reset values:
  - state `ARB_IDLE`, starvation counter 0.
  - `out_busy`, `out_issue_valid`, `out_issue_rob_index`, `out_issue_is_ls` all 0.
  - Grants forced to 0 while `in_rst` is high.
- Reset mid-drain:
  - state returns to `ARB_IDLE` at that edge.
  - the in-flight `dmem` write is not cancelled.

## Configuration
- `FU_ARB_STARVE_GUARD_EN` defined:
  - A counter increments each cycle `ls_ok & alu_ok`, i.e. LS loses.
  - The counter clears on any LS grant, on flush, and on reset.
  - When the counter reaches `STARVE_LIMIT`, `out_ls_grant = ls_ok` and `out_alu_grant = alu_ok & !ls_ok`.
  - The counter saturates; it does not wrap.
- `FU_ARB_STARVE_GUARD_EN` undefined: no counter; pure ALU priority; `STARVE_LIMIT` unused.

## Structure
- `data_structures.sv` holds:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_DRAIN1`, `ARB_DRAIN2`).
  - constant `FU_ARB_STORE_DRAIN_CYCLES = 2`.
- The drain FSM is natural as one sub-module, `ls_store_drain_fsm`: inputs are clock, reset and the store-grant pulse; output is `busy`. The arbitration logic stays in the top module.

## Test plan
- ALU req and LS load req both held for 10 cycles:
  - guard undefined: ALU granted all 10 cycles, no LS grant.
  - guard defined, `STARVE_LIMIT=4`: LS granted in cycle 5, ALU again in cycle 6, LS again in cycle 10.
- LS store, ROB index 5, head 3, no ALU req:
  - no grant while head is 3.
  - head becomes 5: `out_ls_grant` the same cycle, `out_busy`=1 for the next 2 cycles.
  - a load req during those cycles is not granted; it is granted in the 3rd cycle.
- Both req with `in_flush`=1: both grants 0; next cycle `out_issue_valid`=0.
- Reset asserted during `ARB_DRAIN1`: next cycle `out_busy`=0 and a pending load is granted immediately.
- ALU grant with ROB index 7 at cycle N: at N+1 `out_issue_valid`=1, `out_issue_rob_index`=7, `out_issue_is_ls`=0.
- Store at head plus ALU req: ALU granted first; store granted the following cycle; `out_issue_is_ls`=1 one cycle later.
